// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the two-requester capture arbiter: FSM states,
// source identifiers and the default datapath width.
package mux_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// Bundle of the two requester ports and the output port of mux_arbiter.
interface mux_arbiter_if
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             gnt_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  // Handshakes: a requester holds req_x and data_x until the cycle gnt_x is
  // high, and the word is captured at that edge. A word on the output moves
  // only at an edge where out_valid and out_ready are both high.
  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, out_valid, out_data, out_src
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux_arbiter_mux.sv
// Plain two-way word selector: sel=0 passes inA, sel=1 passes inB.
module WideMux2x1
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] muxOut
);

  assign muxOut = sel ? inB : inA;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter feeding a single-entry output register; ties
// alternate between A and B, and a full register can drain and refill in one cycle.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mux_arbiter_if.slave  bus,
  output state_t        dbgState
);

  state_t           state;
  logic [WIDTH-1:0] outData;
  logic             outSrc;
  logic             lastSrc;
  logic             captureSlot;
  logic             grantA;
  logic             grantB;
  logic [WIDTH-1:0] muxOut;

  // out_ready only opens the slot; it never picks the winner.
  always_comb begin
    captureSlot = 1'b0;
    grantA      = 1'b0;
    grantB      = 1'b0;
    if (!reset) begin
      captureSlot = (state == EMPTY) || bus.out_ready;
    end
    if (captureSlot) begin
      if (bus.req_a && bus.req_b) begin
        grantA = (lastSrc == SRC_B);
        grantB = (lastSrc == SRC_A);
      end else begin
        grantA = bus.req_a;
        grantB = bus.req_b;
      end
    end
  end

  WideMux2x1 #(.WIDTH(WIDTH)) uSelect (
    .sel    (grantB),
    .inA    (bus.data_a),
    .inB    (bus.data_b),
    .muxOut (muxOut)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      outData <= '0;
      outSrc  <= SRC_A;
      lastSrc <= SRC_B;
    end else if (grantA || grantB) begin
      state   <= FULL;
      outData <= muxOut;
      outSrc  <= grantB ? SRC_B : SRC_A;
      lastSrc <= grantB ? SRC_B : SRC_A;
    end else if (captureSlot) begin
      // Slot with no winner: the held word (if any) was drained.
      state <= EMPTY;
    end
  end

  assign bus.gnt_a     = grantA;
  assign bus.gnt_b     = grantB;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = outData;
  assign bus.out_src   = outSrc;
  assign dbgState      = state;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed vector table for the named scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  localparam int W = 32;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbgState;
  int     errors = 0;
  int     checks = 0;

  mux_arbiter_if #(.WIDTH(W)) bus ();

  mux_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         reqA;
    logic         reqB;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         ready;
    logic         expGntA;
    logic         expGntB;
    logic         expValid;
    logic [W-1:0] expData;
    logic         expSrc;
  } vec_t;

  vec_t vecs[18];

  // Reference model state: queue of unconsumed words plus the output latch.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mData;
  logic         mSrc;
  logic         mLastWasB;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ra, input logic rb,
                       input logic [W-1:0] da, input logic [W-1:0] db, input logic rdy);
    reset         = r;
    bus.req_a     = ra;
    bus.req_b     = rb;
    bus.data_a    = da;
    bus.data_b    = db;
    bus.out_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic ra, logic rb, logic [W-1:0] da, logic [W-1:0] db,
                              logic rdy, logic ga, logic gb, logic v, logic [W-1:0] d, logic s);
    vec_t x;
    x.rst = r; x.reqA = ra; x.reqB = rb; x.dataA = da; x.dataB = db; x.ready = rdy;
    x.expGntA = ga; x.expGntB = gb; x.expValid = v; x.expData = d; x.expSrc = s;
    return x;
  endfunction

  initial begin
    logic [W-1:0] AA;
    logic [W-1:0] BB;
    AA = 32'hDEADBEEF;
    BB = 32'hCAFEBABE;

    // Columns: rst reqA reqB dataA dataB ready | gntA gntB valid data src
    vecs[0]  = mk(1, 1, 1, AA, BB, 1,  0, 0, 0, 32'h0, 0);
    vecs[1]  = mk(0, 1, 0, AA, BB, 1,  1, 0, 0, 32'h0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h11111111, 32'h22222222, 1,  0, 0, 1, AA, 0);
    vecs[3]  = mk(0, 0, 0, 32'h33333333, 32'h44444444, 1,  0, 0, 0, AA, 0);
    vecs[4]  = mk(1, 0, 0, AA, BB, 1,  0, 0, 0, AA, 0);
    vecs[5]  = mk(0, 1, 1, AA, BB, 1,  1, 0, 0, 32'h0, 0);
    vecs[6]  = mk(0, 1, 1, AA, BB, 1,  0, 1, 1, AA, 0);
    vecs[7]  = mk(0, 1, 1, AA, BB, 1,  1, 0, 1, BB, 1);
    vecs[8]  = mk(0, 1, 1, AA, BB, 1,  0, 1, 1, AA, 0);
    vecs[9]  = mk(0, 1, 0, AA, BB, 0,  0, 0, 1, BB, 1);
    vecs[10] = mk(0, 1, 0, AA, BB, 0,  0, 0, 1, BB, 1);
    vecs[11] = mk(0, 1, 0, AA, BB, 0,  0, 0, 1, BB, 1);
    vecs[12] = mk(0, 1, 0, AA, BB, 0,  0, 0, 1, BB, 1);
    vecs[13] = mk(0, 1, 0, AA, BB, 0,  0, 0, 1, BB, 1);
    vecs[14] = mk(0, 1, 0, AA, BB, 1,  1, 0, 1, BB, 1);
    vecs[15] = mk(1, 0, 1, AA, BB, 1,  0, 0, 1, AA, 0);
    vecs[16] = mk(0, 1, 1, AA, BB, 1,  1, 0, 0, 32'h0, 0);
    vecs[17] = mk(0, 0, 0, AA, BB, 1,  0, 0, 1, AA, 0);

    // Clock/reset block
    drive(1, 1, 1, AA, BB, 1);
    @(negedge clk);
    check("reset_gnt_a", bus.gnt_a, 0);
    check("reset_gnt_b", bus.gnt_b, 0);
    next_cycle();
    next_cycle();
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_src", bus.out_src, 0);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].reqA, vecs[i].reqB, vecs[i].dataA, vecs[i].dataB, vecs[i].ready);
      @(negedge clk);
      check($sformatf("vec%0d_gnt_a", i), bus.gnt_a, vecs[i].expGntA);
      check($sformatf("vec%0d_gnt_b", i), bus.gnt_b, vecs[i].expGntB);
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].expValid);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].expData);
      check($sformatf("vec%0d_src", i), bus.out_src, vecs[i].expSrc);
      check($sformatf("vec%0d_state", i), dbgState == FULL, vecs[i].expValid);
      next_cycle();
    end

    // Randomized phase: start from a known reset
    drive(1, 0, 0, '0, '0, 0);
    next_cycle();
    exp_q.delete();
    mData     = '0;
    mSrc      = 1'b0;
    mLastWasB = 1'b1;

    for (int c = 0; c < 400; c++) begin
      logic         r, ra, rb, rdy, slot, wantA, wantB;
      logic [W-1:0] da, db;
      r   = ($urandom_range(0, 39) == 0);
      ra  = ($urandom_range(0, 99) < 60);
      rb  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 65);
      da  = $urandom;
      db  = $urandom;
      drive(r, ra, rb, da, db, rdy);

      // A slot exists when nothing is held or the held word leaves now.
      slot  = !r && (exp_q.size() == 0 || rdy);
      wantA = 1'b0;
      wantB = 1'b0;
      if (slot) begin
        if (ra && rb) begin
          if (mLastWasB) wantA = 1'b1; else wantB = 1'b1;
        end else begin
          wantA = ra;
          wantB = rb;
        end
      end

      @(negedge clk);
      check($sformatf("rnd%0d_gnt_a", c), bus.gnt_a, wantA);
      check($sformatf("rnd%0d_gnt_b", c), bus.gnt_b, wantB);
      check($sformatf("rnd%0d_valid", c), bus.out_valid, exp_q.size() != 0);
      check($sformatf("rnd%0d_data", c), bus.out_data, mData);
      check($sformatf("rnd%0d_src", c), bus.out_src, mSrc);

      if (r) begin
        exp_q.delete();
        mData     = '0;
        mSrc      = 1'b0;
        mLastWasB = 1'b1;
      end else begin
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (wantA || wantB) begin
          exp_q.push_back(wantB ? db : da);
          mData     = wantB ? db : da;
          mSrc      = wantB;
          mLastWasB = wantB;
        end
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of both requester ports and the output.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_a  input  1  requester A has a word pending.
REQ-005 SHALL have port data_a  input  WIDTH  requester A word; stable while req_a is high and gnt_a is low.
REQ-006 SHALL have port gnt_a  output  1  high for exactly the cycle in which data_a is captured.
REQ-007 SHALL have ports req_b, data_b and gnt_b, with the same directions, widths and meanings for requester B.
REQ-008 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL have port out_data  output  WIDTH  the registered selected word.
REQ-010 SHALL have port out_src  output  1  source of out_data: 0 = A, 1 = B.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts out_data at this edge when out_valid is high.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL have a capture slot in a cycle iff state is EMPTY, or state is FULL and out_ready=1 (drain and refill in the same cycle).
REQ-014 SHALL grant, in a capture-slot cycle, as follows: only req_a high -> A; only req_b high -> B; both high -> the requester not recorded in last_src; neither -> none.
REQ-015 SHALL drive gnt_a/gnt_b combinationally in the granting cycle, never both high, and never high outside a capture slot.
REQ-016 SHALL, at the edge ending a granting cycle, load out_data with the granted word via the select mux, set out_src and last_src to the winner, and enter or stay in FULL.
REQ-017 SHALL, at the edge ending a capture-slot cycle with no grant, go to EMPTY when out_ready drained the word; out_data and out_src then hold their last values.
REQ-018 SHALL, when FULL and out_ready=0, hold out_data and out_src stable, keep gnt_a and gnt_b low, and keep both requests pending.
REQ-019 SHALL have latency 1: a request granted in cycle N appears with out_valid=1 in cycle N+1.
REQ-020 SHALL sustain one word per cycle with out_ready held high, alternating A/B while both request.
REQ-021 SHALL ignore req_x changes and data_x values outside its own granting cycle.
REQ-022 SHALL NOT have the consumer's out_ready affect gnt_x combinationally except through the capture-slot rule in REQ-013.

Reset
REQ-023 SHALL, while reset=1 at an edge, force state EMPTY, out_valid=0, out_data=0, out_src=0, and last_src=B (A wins the first tie).
REQ-024 SHALL hold gnt_a=gnt_b=0 during any cycle with reset=1, regardless of requests.
REQ-025 SHALL discard a word held in FULL when reset is asserted mid-operation; no grant is lost, since none is issued while reset is high.

Structure
REQ-026 SHALL take the FSM state encodings (EMPTY, FULL), the source encodings (SRC_A=0, SRC_B=1) and the default WIDTH from a shared package.
REQ-027 SHALL instantiate exactly one sub-module, WideMux2x1, selecting data_a/data_b by the grant decision; arbitration logic is local.

Verification
REQ-028 SHALL verify a single requester: after reset, req_a=1 with data_a=32'hDEADBEEF and out_ready=1 -> gnt_a=1 in that cycle; next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=0.
REQ-029 SHALL verify tie and round-robin: req_a=req_b=1 continuously, data_a=32'hDEADBEEF, data_b=32'hCAFEBABE, out_ready=1 -> out_data sequence DEADBEEF, CAFEBABE, DEADBEEF, CAFEBABE on consecutive cycles.
REQ-030 SHALL verify backpressure: FULL with 32'hCAFEBABE, out_ready=0 for 5 cycles, req_a=1 -> out_data stable and gnt_a=0 throughout; out_ready=1 -> gnt_a=1 that cycle, next out_data=32'hDEADBEEF.
REQ-031 SHALL verify drain to empty: one word, out_ready=1, no further requests -> out_valid falls after one cycle and no gnt pulses occur.
REQ-032 SHALL verify reset mid-operation: FULL with 32'hDEADBEEF and req_b=1, reset=1 for one cycle -> gnt_b=0 during reset, then out_valid=0 and out_data=0; next tie grants A.
